// File: rtl/spu32_cpu_fetch.sv
// spu32_cpu_fetch: single-outstanding instruction fetch unit with a one-entry
// holding register, redirect/discard handling and misaligned-target fault.
module spu32_cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_ready,
    input  logic        I_redirect,
    input  logic [31:0] I_redirect_pc,
    output logic        O_bus_req,
    output logic [31:0] O_bus_addr,
    input  logic        I_bus_ack,
    input  logic [31:0] I_bus_data,
    output logic [31:0] O_instr,
    output logic [31:0] O_pc,
    output logic        O_valid,
    output logic        O_fault
);
    typedef enum logic [2:0] {START, FETCH, DISCARD, HOLD, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d, instr_q, instr_d, pc_q, pc_d;
    logic        valid_q, valid_d, fault_q, fault_d, pend_q, pend_d;
    logic        mis;

    assign mis        = I_redirect_pc[1:0] != 2'b00;
    assign O_bus_req  = state_q == FETCH || state_q == DISCARD;
    assign O_bus_addr = req_addr_q;
    assign O_instr    = instr_q;
    assign O_pc       = pc_q;
    assign O_valid    = valid_q;
    assign O_fault    = fault_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        pend_d     = pend_q;
        case (state_q)
            START: begin
                state_d    = FETCH;
                req_addr_d = fetch_pc_q;
            end
            FETCH: begin
                if (I_redirect) begin
                    fetch_pc_d = I_redirect_pc;
                    if (mis) begin
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                        pend_d  = !I_bus_ack;
                        state_d = I_bus_ack ? FAULT : DISCARD;
                    end else if (I_bus_ack) begin
                        req_addr_d = I_redirect_pc;
                    end else begin
                        state_d = DISCARD;
                    end
                end else if (I_bus_ack) begin
                    instr_d    = I_bus_data;
                    pc_d       = req_addr_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = req_addr_q + 32'd4;
                    state_d    = HOLD;
                end
            end
            DISCARD: begin
                // A later redirect supersedes both the target and any pending fault.
                if (I_redirect) begin
                    fetch_pc_d = I_redirect_pc;
                    pend_d     = mis;
                    fault_d    = mis;
                end
                if (I_bus_ack) begin
                    req_addr_d = I_redirect ? I_redirect_pc : fetch_pc_q;
                    state_d    = (I_redirect ? mis : pend_q) ? FAULT : FETCH;
                    pend_d     = 1'b0;
                end
            end
            HOLD: begin
                if (I_redirect) begin
                    valid_d    = 1'b0;
                    fetch_pc_d = I_redirect_pc;
                    fault_d    = mis;
                    req_addr_d = mis ? req_addr_q : I_redirect_pc;
                    state_d    = mis ? FAULT : FETCH;
                end else if (I_ready) begin
                    valid_d    = 1'b0;
                    req_addr_d = fetch_pc_q;
                    state_d    = FETCH;
                end
            end
            FAULT: begin
                if (I_redirect && !mis) begin
                    fault_d    = 1'b0;
                    fetch_pc_d = I_redirect_pc;
                    req_addr_d = I_redirect_pc;
                    state_d    = FETCH;
                end
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q    <= START;
            fetch_pc_q <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            instr_q    <= 32'd0;
            pc_q       <= 32'd0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            pend_q     <= pend_d;
        end
    end
endmodule
